// File: rtl/clock_pkg.sv
// Shared clock-time definitions: BCD digit type, digit validation and the
// 24h -> 12h display lookup used by the hour counter and the display driver.
package clock_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t  BCD_MAX_DIGIT  = 4'd9;
   localparam int unsigned HOURS_PER_DAY  = 24;
   localparam int unsigned HOURS_PER_HALF = 12;

   // 12h BCD display value for each 24h hour (index = binary hour).
   localparam logic [7:0] AMPM_HOUR_LUT [HOURS_PER_DAY] = '{
      8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11,
      8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11
   };

   // True when the nibble is a legal BCD digit.
   function automatic logic bcd_valid(input bcd_digit_t d);
      return d <= BCD_MAX_DIGIT;
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit: load, increment with 9->0 carry, decrement with 0->9 borrow.
// The caller guarantees i_inc and i_dec are never both asserted.
module bcd_digit_counter
   import clock_pkg::*;
#(
   parameter bcd_digit_t RESET_DIGIT = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_inc,
   input  logic       i_dec,
   input  logic       i_load,
   input  bcd_digit_t i_load_val,
   output bcd_digit_t o_digit,
   output logic       o_carry,
   output logic       o_borrow
);

   bcd_digit_t r_digit;

   // Digit register: load wins, then single-step up or down with wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit <= RESET_DIGIT;
      end else if (i_load) begin
         r_digit <= i_load_val;
      end else if (i_inc) begin
         r_digit <= (r_digit == BCD_MAX_DIGIT) ? 4'd0 : r_digit + 4'd1;
      end else if (i_dec) begin
         r_digit <= (r_digit == 4'd0) ? BCD_MAX_DIGIT : r_digit - 4'd1;
      end
   end

   assign o_digit  = r_digit;
   assign o_carry  = i_inc & (r_digit == BCD_MAX_DIGIT);
   assign o_borrow = i_dec & (r_digit == 4'd0);

endmodule

// File: rtl/bcd_modulo_counter.sv
// N-digit BCD modulo counter for clock time units with cascade carry/borrow,
// validated parallel load and optional 12h/AM-PM display mapping.
// Optional feature macro: BCD_COUNTER_AMPM_EN (adds military_time / pm ports).
module bcd_modulo_counter
   import clock_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 2,
   parameter int unsigned MODULUS     = 24,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    dec,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic                    carry_out,
   output logic                    borrow_out,
   output logic                    load_err,
`ifdef BCD_COUNTER_AMPM_EN
   input  logic                    military_time,
   output logic                    pm,
`endif
   output logic [4*NUM_DIGITS-1:0] data_out
);

   localparam int unsigned DW = 4 * NUM_DIGITS;

   // Binary -> packed BCD, LS digit in the bottom nibble.
   function automatic logic [DW-1:0] bin_to_bcd(input int unsigned b);
      logic [DW-1:0] r;
      int unsigned   v;
      r = '0;
      v = b;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Packed BCD -> binary; only meaningful when every nibble is a legal digit.
   function automatic logic [31:0] bcd_to_bin(input logic [DW-1:0] b);
      logic [31:0] acc;
      acc = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         acc = acc * 32'd10 + 32'(b[i*4 +: 4]);
      end
      return acc;
   endfunction

   localparam logic [DW-1:0] MAX_BCD   = bin_to_bcd(MODULUS - 1);
   localparam logic [DW-1:0] RESET_BCD = bin_to_bcd(RESET_VALUE);

   // Reject parameter sets the counter cannot represent.
   if (NUM_DIGITS < 1 || NUM_DIGITS > 9) begin : g_bad_digits
      $error("bcd_modulo_counter: NUM_DIGITS must be 1..9");
   end
   if (MODULUS < 2 || MODULUS > 10 ** NUM_DIGITS) begin : g_bad_modulus
      $error("bcd_modulo_counter: MODULUS out of range for NUM_DIGITS");
   end
   if (RESET_VALUE >= MODULUS) begin : g_bad_reset
      $error("bcd_modulo_counter: RESET_VALUE must be below MODULUS");
   end

   logic [DW-1:0]       w_count;
   logic                w_up;
   logic                w_dn;
   logic                w_at_max;
   logic                w_at_zero;
   logic                w_nibbles_ok;
   logic                w_load_ok;
   logic                w_dig_load;
   logic [DW-1:0]       w_dig_val;
   logic [NUM_DIGITS:0] w_inc_chain;
   logic [NUM_DIGITS:0] w_dec_chain;
   logic                w_unused_top_chain;
   logic                r_load_err;

   // Load outranks counting; simultaneous en and dec cancel.
   assign w_up      = en & ~dec & ~load;
   assign w_dn      = dec & ~en & ~load;
   assign w_at_max  = (w_count == MAX_BCD);
   assign w_at_zero = (w_count == '0);

   assign carry_out  = w_up & w_at_max;
   assign borrow_out = w_dn & w_at_zero;

   // Load is legal only when every nibble is a BCD digit and the value fits the modulus.
   always_comb begin
      w_nibbles_ok = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (!bcd_valid(load_data[i*4 +: 4])) begin
            w_nibbles_ok = 1'b0;
         end
      end
   end

   assign w_load_ok = w_nibbles_ok && (bcd_to_bin(load_data) < 32'(MODULUS));

   // Modulus wraps reuse the digit load path: 0 on wrap-up, MODULUS-1 on wrap-down.
   assign w_dig_load = (load & w_load_ok) | carry_out | borrow_out;
   assign w_dig_val  = load ? load_data : (w_up ? '0 : MAX_BCD);

   // Ripple enables start at the LS digit and are suppressed on a modulus wrap.
   assign w_inc_chain[0] = w_up & ~w_at_max;
   assign w_dec_chain[0] = w_dn & ~w_at_zero;

   for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
      bcd_digit_t w_digit;

      bcd_digit_counter #(
         .RESET_DIGIT (RESET_BCD[g*4 +: 4])
      ) u_digit (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_inc      (w_inc_chain[g]),
         .i_dec      (w_dec_chain[g]),
         .i_load     (w_dig_load),
         .i_load_val (w_dig_val[g*4 +: 4]),
         .o_digit    (w_digit),
         .o_carry    (w_inc_chain[g+1]),
         .o_borrow   (w_dec_chain[g+1])
      );

      assign w_count[g*4 +: 4] = w_digit;
   end

   // The MS digit never ripples out because a wrap always happens first.
   assign w_unused_top_chain = w_inc_chain[NUM_DIGITS] | w_dec_chain[NUM_DIGITS];

   // Sticky load rejection flag, updated on every load strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_err <= 1'b0;
      end else if (load) begin
         r_load_err <= ~w_load_ok;
      end
   end

   assign load_err = r_load_err;

`ifdef BCD_COUNTER_AMPM_EN
   if (!(NUM_DIGITS == 2 && MODULUS == HOURS_PER_DAY)) begin : g_bad_ampm
      $error("bcd_modulo_counter: AM/PM mapping requires NUM_DIGITS=2, MODULUS=24");
   end

   logic [4:0] w_hour_bin;
   assign w_hour_bin = 5'(bcd_to_bin(w_count));

   // Display-only 12h mapping; the stored count remains 24h.
   always_comb begin
      data_out = w_count;
      pm       = 1'b0;
      if (!military_time) begin
         data_out = DW'(AMPM_HOUR_LUT[w_hour_bin]);
         pm       = (w_hour_bin >= 5'(HOURS_PER_HALF));
      end
   end
`else
   assign data_out = w_count;
`endif

endmodule

// File: tb/tb_bcd_modulo_counter.sv
// Scoreboard bench for bcd_modulo_counter: two instances (hours MOD 24 and
// minutes MOD 60, or two MOD 24 hour counters with AM/PM), directed + random.
module tb_bcd_modulo_counter;

   localparam int unsigned MOD_A = 24;
`ifdef BCD_COUNTER_AMPM_EN
   localparam int unsigned MOD_B = 24;
`else
   localparam int unsigned MOD_B = 60;
`endif

   typedef struct {
      bit         en;
      bit         dec;
      bit         load;
      bit         mil;
      logic [7:0] ld;
   } stim_t;

   typedef struct {
      logic [7:0] data;
      bit         carry;
      bit         borrow;
      bit         lerr;
      bit         pm;
   } exp_t;

   typedef struct {
      exp_t a;
      exp_t b;
   } exp_pair_t;

   logic       clk;
   logic       rst_n;
   logic       en_a, dec_a, load_a, mil_a, carry_a, borrow_a, lerr_a, pm_a;
   logic       en_b, dec_b, load_b, mil_b, carry_b, borrow_b, lerr_b, pm_b;
   logic [7:0] ld_a, ld_b, data_a, data_b;

   exp_pair_t  sb_q[$];
   int         n_checks;
   int         n_pass;

   // Reference model state: plain binary counts.
   int         cnt[2];
   bit         lerr[2];

   bcd_modulo_counter #(.NUM_DIGITS(2), .MODULUS(MOD_A), .RESET_VALUE(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .dec(dec_a), .load(load_a), .load_data(ld_a),
      .carry_out(carry_a), .borrow_out(borrow_a), .load_err(lerr_a),
`ifdef BCD_COUNTER_AMPM_EN
      .military_time(mil_a), .pm(pm_a),
`endif
      .data_out(data_a)
   );

   bcd_modulo_counter #(.NUM_DIGITS(2), .MODULUS(MOD_B), .RESET_VALUE(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .dec(dec_b), .load(load_b), .load_data(ld_b),
      .carry_out(carry_b), .borrow_out(borrow_b), .load_err(lerr_b),
`ifdef BCD_COUNTER_AMPM_EN
      .military_time(mil_b), .pm(pm_b),
`endif
      .data_out(data_b)
   );

`ifndef BCD_COUNTER_AMPM_EN
   assign pm_a = 1'b0;
   assign pm_b = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Expected display: 24h value, or 12h value when the AM/PM option is built and selected.
   function automatic logic [7:0] disp(input int c, input bit mil);
`ifdef BCD_COUNTER_AMPM_EN
      int h;
      if (mil) return to_bcd(c);
      h = c % 12;
      if (h == 0) h = 12;
      return to_bcd(h);
`else
      if (mil) return to_bcd(c);
      return to_bcd(c);
`endif
   endfunction

   function automatic stim_t mk(input bit e, input bit d, input bit l,
                                input logic [7:0] v, input bit m = 1'b0);
      stim_t s;
      s.en = e; s.dec = d; s.load = l; s.ld = v; s.mil = m;
      return s;
   endfunction

   // One cycle of the reference model: returns what should be visible, then advances.
   function automatic exp_t model_step(input int idx, input stim_t s, input bit rst);
      exp_t       e;
      int         m;
      logic [3:0] hi, lo;
      int         val;
      m = (idx == 0) ? int'(MOD_A) : int'(MOD_B);
      if (rst) begin
         cnt[idx]  = 0;
         lerr[idx] = 1'b0;
      end
      e.data   = disp(cnt[idx], s.mil);
`ifdef BCD_COUNTER_AMPM_EN
      e.pm     = !s.mil && (cnt[idx] >= 12);
`else
      e.pm     = 1'b0;
`endif
      e.lerr   = lerr[idx];
      e.carry  = !rst && s.en && !s.dec && !s.load && (cnt[idx] == m - 1);
      e.borrow = !rst && s.dec && !s.en && !s.load && (cnt[idx] == 0);
      if (!rst) begin
         if (s.load) begin
            hi  = s.ld[7:4];
            lo  = s.ld[3:0];
            val = int'(hi) * 10 + int'(lo);
            if (hi <= 4'd9 && lo <= 4'd9 && val < m) begin
               cnt[idx]  = val;
               lerr[idx] = 1'b0;
            end else begin
               lerr[idx] = 1'b1;
            end
         end else if (s.en && !s.dec) begin
            cnt[idx] = (cnt[idx] + 1) % m;
         end else if (s.dec && !s.en) begin
            cnt[idx] = (cnt[idx] + m - 1) % m;
         end
      end
      return e;
   endfunction

   task automatic step(input stim_t sa, input stim_t sb, input bit rst = 1'b0);
      exp_pair_t p;
      stim_t     qa, qb;
      qa = rst ? mk(0, 0, 0, 8'h00, sa.mil) : sa;
      qb = rst ? mk(0, 0, 0, 8'h00, sb.mil) : sb;
      @(posedge clk);
      #1;
      rst_n  = !rst;
      en_a   = qa.en; dec_a = qa.dec; load_a = qa.load; ld_a = qa.ld; mil_a = qa.mil;
      en_b   = qb.en; dec_b = qb.dec; load_b = qb.load; ld_b = qb.ld; mil_b = qb.mil;
      p.a    = model_step(0, qa, rst);
      p.b    = model_step(1, qb, rst);
      sb_q.push_back(p);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
   endtask

   // Monitor: every cycle with an issued stimulus, compare outputs mid-cycle.
   initial begin
      exp_pair_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("a_data",   data_a,          e.a.data);
            check("a_carry",  8'(carry_a),     8'(e.a.carry));
            check("a_borrow", 8'(borrow_a),    8'(e.a.borrow));
            check("a_lerr",   8'(lerr_a),      8'(e.a.lerr));
            check("b_data",   data_b,          e.b.data);
            check("b_carry",  8'(carry_b),     8'(e.b.carry));
            check("b_borrow", 8'(borrow_b),    8'(e.b.borrow));
            check("b_lerr",   8'(lerr_b),      8'(e.b.lerr));
`ifdef BCD_COUNTER_AMPM_EN
            check("a_pm",     8'(pm_a),        8'(e.a.pm));
            check("b_pm",     8'(pm_b),        8'(e.b.pm));
`endif
         end
      end
   end

   initial begin
      stim_t idle, sa, sb;
      int    r;
      n_checks = 0;
      n_pass   = 0;
      cnt[0] = 0; cnt[1] = 0; lerr[0] = 1'b0; lerr[1] = 1'b0;
      rst_n = 1'b0;
      en_a = 0; dec_a = 0; load_a = 0; ld_a = 0; mil_a = 0;
      en_b = 0; dec_b = 0; load_b = 0; ld_b = 0; mil_b = 0;
      idle = mk(0, 0, 0, 8'h00);

      step(idle, idle, 1'b1);
      step(idle, idle, 1'b1);

      // Counter B: 60 ticks, carry on the last one, then 00.
      for (int i = 0; i < 60; i++) step(idle, mk(1, 0, 0, 8'h00));
      step(idle, idle);

      // Counter A: load 23, wrap up, wrap down.
      step(mk(0, 0, 1, 8'h23), idle);
      step(mk(1, 0, 0, 8'h00), idle);
      step(mk(0, 1, 0, 8'h00), idle);
      step(idle, idle);
      // Rejected loads then an accepted one.
      step(mk(0, 0, 1, 8'h1A), idle);
      step(mk(0, 0, 1, 8'h24), idle);
      step(mk(0, 0, 1, 8'h07), idle);
      step(idle, idle);
      // en+dec cancel; load beats en.
      step(mk(0, 0, 1, 8'h23), idle);
      step(mk(1, 1, 0, 8'h00), idle);
      step(mk(1, 0, 1, 8'h05), idle);
      step(idle, idle);

      // 12h sweep over a full day and display toggle at 15h.
      step(mk(0, 0, 1, 8'h00), idle);
      for (int i = 0; i < 24; i++) step(mk(1, 0, 0, 8'h00), idle);
      step(mk(0, 0, 1, 8'h15), idle);
      step(mk(0, 0, 0, 8'h00, 1'b0), idle);
      step(mk(0, 0, 0, 8'h00, 1'b1), idle);
      step(mk(0, 0, 0, 8'h00, 1'b0), idle);
      step(mk(0, 0, 0, 8'h00, 1'b1), idle);

      // Counter B: reset mid-count at 37 with load_err set.
      step(idle, mk(0, 0, 1, 8'h37));
      step(idle, mk(0, 0, 1, 8'hA0));
      step(idle, idle);
      step(idle, idle, 1'b1);
      step(idle, idle);

      // Randomized traffic on both counters.
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 2; k++) begin
            r = int'($urandom_range(0, 9));
            sa = mk(r < 4 || r == 7, (r >= 4 && r <= 7), r == 8, 8'h00, 1'($urandom_range(0, 1)));
            if (sa.load) sa.en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) sa.ld = to_bcd(int'($urandom_range(0, 99)));
            else sa.ld = 8'($urandom);
            if (k == 0) sb = sa;
         end
         step(sb, sa, $urandom_range(0, 99) == 0);
      end
      step(idle, idle);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
